// File: rtl/ex_stage_pkg.sv
// mips16_ex_pkg: shared types and field positions for the mips_16 execute stage.
//   alu_cmd_e  : ALU command encoding carried in pipeline_reg_in[57:54]
//   ex_state_e : execute-stage sequencing states
//   IN_* / OUT_* localparams locate every field of the ID/EX and EX/MEM registers.
package mips16_ex_pkg;

   localparam int unsigned EX_IN_W  = 58;
   localparam int unsigned EX_OUT_W = 38;

   // ID/EX register fields
   localparam int unsigned IN_CMD_MSB  = 57;
   localparam int unsigned IN_CMD_LSB  = 54;
   localparam int unsigned IN_SRC1_MSB = 53;
   localparam int unsigned IN_SRC1_LSB = 38;
   localparam int unsigned IN_SRC2_MSB = 37;
   localparam int unsigned IN_SRC2_LSB = 22;
   localparam int unsigned IN_MWE      = 21;
   localparam int unsigned IN_MWD_MSB  = 20;
   localparam int unsigned IN_MWD_LSB  = 5;
   localparam int unsigned IN_WB_MSB   = 4;
   localparam int unsigned IN_WB_LSB   = 0;
   localparam int unsigned IN_DEST_MSB = 3;
   localparam int unsigned IN_DEST_LSB = 1;

   // EX/MEM register fields
   localparam int unsigned OUT_RES_MSB  = 37;
   localparam int unsigned OUT_RES_LSB  = 22;
   localparam int unsigned OUT_PASS_MSB = 21;
   localparam int unsigned OUT_PASS_LSB = 0;

   typedef enum logic [3:0] {
      CMD_NONE = 4'd0,
      CMD_ADD  = 4'd1,
      CMD_SUB  = 4'd2,
      CMD_AND  = 4'd3,
      CMD_OR   = 4'd4,
      CMD_XOR  = 4'd5,
      CMD_SL   = 4'd6,
      CMD_SR   = 4'd7,
      CMD_SRA  = 4'd8,
      CMD_MUL  = 4'd9
   } alu_cmd_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } ex_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID -> EX -> MEM pipeline bundle for the execute stage.
//   pipeline_reg_in  : 58-bit ID/EX register (driven by ID)
//   pipeline_reg_out : 38-bit EX/MEM register (driven by EX)
//   ex_op_dest       : write-back destination of the instruction in EX (to hazard unit)
//   ex_busy          : stall request towards IF/ID
// master = ID/pipeline side, slave = execute stage.
interface ex_stage_if;
   import mips16_ex_pkg::*;

   logic [EX_IN_W-1:0]  pipeline_reg_in;
   logic [EX_OUT_W-1:0] pipeline_reg_out;
   logic [2:0]          ex_op_dest;
   logic                ex_busy;

   modport master (
      output pipeline_reg_in,
      input  pipeline_reg_out,
      input  ex_op_dest,
      input  ex_busy
   );

   modport slave (
      input  pipeline_reg_in,
      output pipeline_reg_out,
      output ex_op_dest,
      output ex_busy
   );
endinterface

// File: rtl/ex_stage_mul_seq.sv
// ex_mul_seq: shift-add multiplier iterator, one partial product per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : load op_a/op_b, clear accumulator and iteration count
//   op_a/op_b: multiplicand / multiplier
//   done     : high during the final iteration cycle
//   product  : accumulator (low DATA_W bits of op_a*op_b once iterations finish)
module ex_mul_seq #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MUL_ITER = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int unsigned     CNT_W = $clog2(MUL_ITER) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MUL_ITER - 1);
   localparam logic [CNT_W-1:0] END   = CNT_W'(MUL_ITER);

   logic [DATA_W-1:0] a_q, b_q, acc_q;
   logic [CNT_W-1:0]  cnt_q;

   // Iteration stops once cnt reaches MUL_ITER, so the product holds steady
   // while the stage sits in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         a_q   <= op_a;
         b_q   <= op_b;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (cnt_q != END) begin
         if (b_q[0]) acc_q <= acc_q + a_q;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign done    = (cnt_q == LAST);
   assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: mips_16 execute stage (ID -> EX -> MEM).
//   clk, rst : clock, synchronous active-high reset
//   ex_if    : slave side of ex_stage_if
//              pipeline_reg_in  -> {alu_cmd, src1, src2, mem_we, mem_wd, wb[4:0]}
//              pipeline_reg_out <- {alu_result, mem_we, mem_wd, wb[4:0]}
//              ex_op_dest       <- pipeline_reg_in[3:1]
//              ex_busy          <- stall request while a MUL is in progress
// Single-cycle ops register in one clock; MUL runs a shift-add sequence,
// emitting bubbles until the product is written in DONE.
module ex_stage
   import mips16_ex_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MUL_ITER = 16
) (
   input  logic      clk,
   input  logic      rst,
   ex_stage_if.slave ex_if
);

   logic [3:0]                   cmd;
   logic [DATA_W-1:0]            src1, src2;
   logic [3:0]                   shamt;
   logic [OUT_PASS_MSB:0]        pass;
   logic                         is_mul;

   logic [DATA_W-1:0]            alu_res;
   logic [DATA_W-1:0]            product;
   logic                         mul_done;
   logic                         mul_start;
   logic                         busy;

   ex_state_e                    state_q, state_d;
   logic [EX_OUT_W-1:0]          out_q, out_d;

   assign cmd    = ex_if.pipeline_reg_in[IN_CMD_MSB:IN_CMD_LSB];
   assign src1   = ex_if.pipeline_reg_in[IN_SRC1_MSB:IN_SRC1_LSB];
   assign src2   = ex_if.pipeline_reg_in[IN_SRC2_MSB:IN_SRC2_LSB];
   assign shamt  = src2[3:0];
   assign pass   = ex_if.pipeline_reg_in[OUT_PASS_MSB:OUT_PASS_LSB];
   assign is_mul = (cmd == CMD_MUL);

   // Combinational ALU; MUL and reserved codes yield 0 here.
   always_comb begin
      alu_res = '0;
      case (cmd)
         CMD_ADD: alu_res = src1 + src2;
         CMD_SUB: alu_res = src1 - src2;
         CMD_AND: alu_res = src1 & src2;
         CMD_OR:  alu_res = src1 | src2;
         CMD_XOR: alu_res = src1 ^ src2;
         CMD_SL:  alu_res = src1 << shamt;
         CMD_SR:  alu_res = src1 >> shamt;
         CMD_SRA: alu_res = DATA_W'($signed(src1) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   ex_mul_seq #(
      .DATA_W   (DATA_W),
      .MUL_ITER (MUL_ITER)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .op_a    (src1),
      .op_b    (src2),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (is_mul)   state_d = MUL;
         MUL:     if (mul_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      mul_start = 1'b0;
      out_d     = '0;
      case (state_q)
         IDLE: begin
            if (is_mul) begin
               busy      = 1'b1;
               mul_start = 1'b1;
            end else begin
               out_d = {alu_res, pass};
            end
         end
         MUL:     busy  = 1'b1;
         DONE:    out_d = {product, pass};
         default: out_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
   end

   assign ex_if.pipeline_reg_out = out_q;
   assign ex_if.ex_op_dest       = ex_if.pipeline_reg_in[IN_DEST_MSB:IN_DEST_LSB];
   assign ex_if.ex_busy          = busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage with a behavioural ALU model.
module tb_ex_stage;
   import mips16_ex_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_stage_if bus ();

   ex_stage #(.DATA_W(16), .MUL_ITER(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .ex_if (bus)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [57:0] mk(input logic [3:0] cmd, input logic [15:0] s1,
                                      input logic [15:0] s2, input logic [21:0] low);
      return {cmd, s1, s2, low};
   endfunction

   // Reference ALU from plain arithmetic on integers.
   function automatic logic [15:0] ref_alu(input int unsigned cmd, input int unsigned a,
                                           input int unsigned b);
      longint v, p;
      longint unsigned r;
      int unsigned s;
      s = b % 16;
      p = longint'(1) << s;
      r = 0;
      case (cmd)
         1: r = (a + b) % 65536;
         2: r = (a + 65536 - b) % 65536;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (longint'(a) * p) % 65536;
         7: r = a / p;
         8: begin
            v = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
            if (v < 0) v = (v - (p - 1)) / p;
            else       v = v / p;
            r = longint'(v) & 64'hFFFF;
         end
         9: r = (longint'(a) * longint'(b)) % 65536;
         default: r = 0;
      endcase
      return 16'(r);
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      bus.pipeline_reg_in = mk(4'd0, 16'h1234, 16'h5678, 22'h3FFFFF);
      tick;
      tick;
      n_total++;
      if (bus.pipeline_reg_out !== 38'h0)
         $display("FAIL reset_out: got %h expected %h", bus.pipeline_reg_out, 38'h0);
      else n_pass++;
      n_total++;
      if (bus.ex_busy !== 1'b0)
         $display("FAIL reset_busy: got %b expected 0", bus.ex_busy);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_alu_directed;
      logic [3:0]  c  [5] = '{4'd1, 4'd2, 4'd8, 4'd7, 4'd6};
      logic [15:0] s1 [5] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h8000, 16'h0001};
      logic [15:0] s2 [5] = '{16'h0001, 16'h0001, 16'h0004, 16'h0004, 16'h000F};
      logic [15:0] ex [5] = '{16'h8000, 16'hFFFF, 16'hF800, 16'h0800, 16'h8000};
      logic [21:0] low;
      for (int i = 0; i < 5; i++) begin
         low = {1'b0, 16'h0000, 5'b1_011_0};
         bus.pipeline_reg_in = mk(c[i], s1[i], s2[i], low);
         #1;
         n_total++;
         if (bus.ex_busy !== 1'b0)
            $display("FAIL alu_dir_busy[%0d]: got %b expected 0", i, bus.ex_busy);
         else n_pass++;
         tick;
         n_total++;
         if (bus.pipeline_reg_out !== {ex[i], low})
            $display("FAIL alu_dir_out[%0d]: got %h expected %h", i, bus.pipeline_reg_out, {ex[i], low});
         else n_pass++;
      end
   endtask

   task automatic test_alu_random;
      logic [3:0]  c;
      logic [15:0] a, b;
      logic [21:0] low;
      logic [37:0] exp;
      for (int i = 0; i < 60; i++) begin
         c = 4'($urandom_range(0, 14));
         if (c >= 4'd9) c = c + 4'd1;
         a = 16'($urandom);
         b = 16'($urandom);
         low = 22'($urandom);
         bus.pipeline_reg_in = mk(c, a, b, low);
         exp = {ref_alu(c, a, b), low};
         #1;
         n_total++;
         if (bus.ex_op_dest !== low[3:1])
            $display("FAIL alu_rnd_dest: got %h expected %h", bus.ex_op_dest, low[3:1]);
         else n_pass++;
         tick;
         n_total++;
         if (bus.pipeline_reg_out !== exp || bus.ex_busy !== 1'b0)
            $display("FAIL alu_rnd_out cmd=%0d: got %h busy=%b expected %h busy=0",
                     c, bus.pipeline_reg_out, bus.ex_busy, exp);
         else n_pass++;
      end
   endtask

   // Drives a MUL and walks it to the DONE cycle, checking stall and bubbles.
   // Returns with the DUT in DONE, before the result edge.
   task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [21:0] low, input bit perturb);
      bus.pipeline_reg_in = mk(4'd9, a, b, low);
      #1;
      for (int cyc = 1; cyc <= 17; cyc++) begin
         n_total++;
         if (bus.ex_busy !== 1'b1)
            $display("FAIL mul_busy cyc%0d: got %b expected 1", cyc, bus.ex_busy);
         else n_pass++;
         n_total++;
         if (bus.ex_op_dest !== low[3:1])
            $display("FAIL mul_dest cyc%0d: got %h expected %h", cyc, bus.ex_op_dest, low[3:1]);
         else n_pass++;
         tick;
         n_total++;
         if (bus.pipeline_reg_out !== 38'h0)
            $display("FAIL mul_bubble cyc%0d: got %h expected 0", cyc, bus.pipeline_reg_out);
         else n_pass++;
         if (perturb) bus.pipeline_reg_in[53:22] = $urandom;
      end
      n_total++;
      if (bus.ex_busy !== 1'b0)
         $display("FAIL mul_done_busy: got %b expected 0", bus.ex_busy);
      else n_pass++;
   endtask

   task automatic test_mul;
      logic [21:0] low;
      logic [15:0] a, b;
      low = {1'b0, 16'h0000, 5'b1_101_0};
      run_mul(16'h0123, 16'h0010, low, 1'b1);
      tick;
      n_total++;
      if (bus.pipeline_reg_out !== {16'h1230, low})
         $display("FAIL mul_result: got %h expected %h", bus.pipeline_reg_out, {16'h1230, low});
      else n_pass++;
      bus.pipeline_reg_in = mk(4'd1, 16'h0001, 16'h0001, low);
      tick;
      n_total++;
      if (bus.pipeline_reg_out !== {16'h0002, low})
         $display("FAIL mul_next_add: got %h expected %h", bus.pipeline_reg_out, {16'h0002, low});
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         low = 22'($urandom);
         run_mul(a, b, low, 1'b1);
         tick;
         n_total++;
         if (bus.pipeline_reg_out !== {ref_alu(9, a, b), low})
            $display("FAIL mul_rnd %h*%h: got %h expected %h", a, b, bus.pipeline_reg_out,
                     {ref_alu(9, a, b), low});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [21:0] low1, low2;
      low1 = {1'b0, 16'h0000, 5'b1_001_1};
      low2 = {1'b0, 16'h0000, 5'b1_110_0};
      run_mul(16'hFFFF, 16'hFFFF, low1, 1'b0);
      tick;
      bus.pipeline_reg_in = mk(4'd9, 16'h0003, 16'h0005, low2);
      n_total++;
      if (bus.pipeline_reg_out !== {16'h0001, low1})
         $display("FAIL b2b_first: got %h expected %h", bus.pipeline_reg_out, {16'h0001, low1});
      else n_pass++;
      run_mul(16'h0003, 16'h0005, low2, 1'b0);
      tick;
      n_total++;
      if (bus.pipeline_reg_out !== {16'h000F, low2})
         $display("FAIL b2b_second: got %h expected %h", bus.pipeline_reg_out, {16'h000F, low2});
      else n_pass++;
   endtask

   task automatic test_rst_mid_mul;
      logic [21:0] low;
      low = {1'b1, 16'hA5A5, 5'b1_111_1};
      bus.pipeline_reg_in = mk(4'd9, 16'h00FF, 16'h00FF, low);
      for (int i = 0; i < 5; i++) tick;
      rst = 1'b1;
      low = {1'b0, 16'h0000, 5'b1_010_0};
      bus.pipeline_reg_in = mk(4'd1, 16'h0002, 16'h0003, low);
      tick;
      rst = 1'b0;
      n_total++;
      if (bus.pipeline_reg_out !== 38'h0 || bus.ex_busy !== 1'b0)
         $display("FAIL rst_mid_mul: got %h busy=%b expected 0 busy=0",
                  bus.pipeline_reg_out, bus.ex_busy);
      else n_pass++;
      tick;
      n_total++;
      if (bus.pipeline_reg_out !== {16'h0005, low})
         $display("FAIL rst_then_add: got %h expected %h", bus.pipeline_reg_out, {16'h0005, low});
      else n_pass++;
      bus.pipeline_reg_in = '0;
      for (int i = 0; i < 20; i++) begin
         tick;
         n_total++;
         if (bus.pipeline_reg_out !== 38'h0 || bus.ex_busy !== 1'b0)
            $display("FAIL rst_no_leak[%0d]: got %h busy=%b expected 0 busy=0",
                     i, bus.pipeline_reg_out, bus.ex_busy);
         else n_pass++;
      end
   endtask

   task automatic test_reserved;
      logic [21:0] low;
      logic [3:0]  c;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin
            c   = 4'd12;
            low = {1'b1, 16'hBEEF, 5'b1_100_1};
         end else begin
            c   = 4'($urandom_range(10, 15));
            low = 22'($urandom);
         end
         bus.pipeline_reg_in = mk(c, 16'($urandom), 16'($urandom), low);
         #1;
         n_total++;
         if (bus.ex_op_dest !== low[3:1] || bus.ex_busy !== 1'b0)
            $display("FAIL rsv_dest: got %h busy=%b expected %h busy=0",
                     bus.ex_op_dest, bus.ex_busy, low[3:1]);
         else n_pass++;
         tick;
         n_total++;
         if (bus.pipeline_reg_out !== {16'h0000, low})
            $display("FAIL rsv_out cmd=%0d: got %h expected %h", c, bus.pipeline_reg_out,
                     {16'h0000, low});
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.pipeline_reg_in = '0;
      test_reset;
      test_alu_directed;
      test_alu_random;
      test_mul;
      test_back_to_back;
      test_rst_mid_mul;
      test_reserved;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
